// File: rtl/sop_sweep_checker_if.sv
// Bundle between the exhaustive sweeper and whatever drives or observes it.
// master: the side that pulses start and supplies the DUT output (bench or
// surrounding logic). slave: the sweeper itself.
`timescale 1ns/1ps

interface sop_sweep_checker_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            dut_y;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            first_err_valid;
    logic [N_IN-1:0] first_err_vec;

    modport master (
        output start, dut_y,
        input  dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec
    );

    modport slave (
        input  start, dut_y,
        output dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec
    );
endinterface

// File: rtl/sop_sweep_checker.sv
// Exhaustive sweeper for an N_IN-input combinational block. Drives vectors
// 0 .. 2^N_IN-1 in order, holds each for HOLD cycles, compares dut_y against
// EXPECT at the last cycle of each hold window and reports pass, mismatch
// count and the lowest failing vector.
// Optional feature macro: SOP_SWEEP_STOP_ON_ERR_EN -- when defined, the sweep
// ends on the sampling edge of the first mismatch.
`timescale 1ns/1ps

module sop_sweep_checker #(
    parameter int                   N_IN   = 3,
    parameter int                   HOLD   = 10,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'b1110_1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sop_sweep_checker_if.slave    bus
);

    // Hold counter needs to reach HOLD-1; a HOLD of 1 still gets one bit.
    localparam int              CW        = (HOLD <= 1) ? 1 : $clog2(HOLD);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          mismatch;
    logic          sample_now;
    logic          last_sample;

    // Compare the DUT output with the truth-table bit of the vector on the bus.
    assign mismatch   = (bus.dut_y != EXPECT[bus.dut_in]);
    assign sample_now = (hold_cnt == HOLD_LAST);

    // Decide whether this sampling edge ends the sweep.
`ifdef SOP_SWEEP_STOP_ON_ERR_EN
    assign last_sample = (bus.dut_in == VEC_LAST) || mismatch;
`else
    assign last_sample = (bus.dut_in == VEC_LAST);
`endif

    // Sweep control FSM with all outputs registered.
    // NOTE: every register here is written with non-blocking assignments so
    // all decisions on an edge see the pre-edge values of state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            hold_cnt            <= '0;
            bus.dut_in          <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.err_count       <= '0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state               <= RUN;
                        hold_cnt            <= '0;
                        bus.dut_in          <= '0;
                        bus.busy            <= 1'b1;
                        bus.done            <= 1'b0;
                        bus.pass            <= 1'b0;
                        bus.err_count       <= '0;
                        bus.first_err_valid <= 1'b0;
                        bus.first_err_vec   <= '0;
                    end
                end

                RUN: begin
                    if (sample_now) begin
                        if (mismatch) begin
                            bus.err_count <= bus.err_count + 1'b1;
                            if (!bus.first_err_valid) begin
                                bus.first_err_valid <= 1'b1;
                                bus.first_err_vec   <= bus.dut_in;
                            end
                        end
                        if (last_sample) begin
                            // dut_in deliberately keeps its last value in DONE.
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (bus.err_count == '0) && !mismatch;
                        end else begin
                            bus.dut_in <= bus.dut_in + 1'b1;
                            hold_cnt   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Bench for sop_sweep_checker: two instances (HOLD=10 and HOLD=1) share start
// and a truth-table driven model of the block under test. Expected results
// come from a table-level reference model (popcount of disagreeing bits,
// lowest disagreeing index, sweep length in cycles).
`timescale 1ns/1ps

module tb_sop_sweep_checker;

    localparam int         N_IN = 3;
    localparam logic [7:0] EXP  = 8'b1110_1000;
    localparam logic [7:0] MAJ  = 8'b1110_1000;
`ifdef SOP_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] model_tbl;
    int         checks;
    int         failures;

    sop_sweep_checker_if #(.N_IN(N_IN)) bus10 ();
    sop_sweep_checker_if #(.N_IN(N_IN)) bus1 ();

    sop_sweep_checker #(.N_IN(N_IN), .HOLD(10), .EXPECT(EXP)) u_dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10.slave)
    );

    sop_sweep_checker #(.N_IN(N_IN), .HOLD(1), .EXPECT(EXP)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Model of the block under test: output is the table bit of the vector.
    assign bus10.dut_y = model_tbl[bus10.dut_in];
    assign bus1.dut_y  = model_tbl[bus1.dut_in];
    assign bus1.start  = bus10.start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: derive the sweep outcome straight from the tables.
    function automatic void ref_model(input logic [7:0] tbl, input int hold,
                                      output int errs, output int first,
                                      output int end_cyc, output int last_vec);
        errs  = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (tbl[v] !== EXP[v]) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        if (STOP && first >= 0) begin
            errs     = 1;
            end_cyc  = (first + 1) * hold;
            last_vec = first;
        end else begin
            end_cyc  = 8 * hold;
            last_vec = 7;
        end
    endfunction

    // Run one sweep from the current negedge; start held for start_len edges.
    task automatic sweep(input string tag, input logic [7:0] tbl, input int start_len);
        int errs, first, end10, last10, end1, last1, fvec;
        ref_model(tbl, 10, errs, first, end10, last10);
        ref_model(tbl, 1, errs, first, end1, last1);
        fvec      = (first < 0) ? 0 : first;
        model_tbl = tbl;
        bus10.start = 1'b1;
        for (int c = 0; c <= end10 + 1; c++) begin
            @(negedge clk);
            if (c == start_len - 1) bus10.start = 1'b0;
            if (c == 0) begin
                check({tag, ":clr_err"},  32'(bus10.err_count), 32'd0);
                check({tag, ":clr_fev"},  32'(bus10.first_err_valid), 32'd0);
                check({tag, ":clr_done"}, 32'(bus10.done), 32'd0);
            end
            if (c < end10) begin
                check({tag, ":busy"},   32'(bus10.busy), 32'd1);
                check({tag, ":dut_in"}, 32'(bus10.dut_in), 32'(c / 10));
            end else begin
                check({tag, ":end_busy"}, 32'(bus10.busy), 32'd0);
                check({tag, ":end_done"}, 32'(bus10.done), 32'd1);
                check({tag, ":pass"},     32'(bus10.pass), 32'(errs == 0));
                check({tag, ":err_cnt"},  32'(bus10.err_count), 32'(errs));
                check({tag, ":fe_valid"}, 32'(bus10.first_err_valid), 32'(first >= 0));
                check({tag, ":fe_vec"},   32'(bus10.first_err_vec), 32'(fvec));
                check({tag, ":last_in"},  32'(bus10.dut_in), 32'(last10));
            end
            if (start_len == 1 && c == end1 - 1)
                check({tag, ":h1_early"}, 32'(bus1.done), 32'd0);
            if (start_len == 1 && c == end1) begin
                check({tag, ":h1_done"},  32'(bus1.done), 32'd1);
                check({tag, ":h1_busy"},  32'(bus1.busy), 32'd0);
                check({tag, ":h1_pass"},  32'(bus1.pass), 32'(errs == 0));
                check({tag, ":h1_err"},   32'(bus1.err_count), 32'(errs));
                check({tag, ":h1_fevec"}, 32'(bus1.first_err_vec), 32'(fvec));
                check({tag, ":h1_last"},  32'(bus1.dut_in), 32'(last1));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"},    32'(bus10.busy), 32'd0);
        check({tag, ":done"},    32'(bus10.done), 32'd0);
        check({tag, ":pass"},    32'(bus10.pass), 32'd0);
        check({tag, ":err_cnt"}, 32'(bus10.err_count), 32'd0);
        check({tag, ":fe_val"},  32'(bus10.first_err_valid), 32'd0);
        check({tag, ":fe_vec"},  32'(bus10.first_err_vec), 32'd0);
        check({tag, ":dut_in"},  32'(bus10.dut_in), 32'd0);
        check({tag, ":h1_done"}, 32'(bus1.done), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_tbl   = MAJ;
        bus10.start = 1'b0;
        rst_n       = 1'b0;

        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct majority model, then stuck-at-0, then vector 5 inverted.
        sweep("maj", MAJ, 1);
        sweep("stuck0", 8'h00, 1);
        sweep("inv5", MAJ ^ 8'h20, 1);

        // start held for 20 cycles must not restart; errors from before cleared.
        sweep("stuck0b", 8'h00, 1);
        sweep("held", MAJ, 20);

        // Asynchronous reset in the middle of vector 3.
        model_tbl   = MAJ;
        bus10.start = 1'b1;
        for (int c = 0; c <= 35; c++) begin
            @(negedge clk);
            if (c == 0) bus10.start = 1'b0;
        end
        check("mid:dut_in", 32'(bus10.dut_in), 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep("fresh", MAJ, 1);

        // Randomised truth tables for the model under test.
        for (int i = 0; i < 4; i++) begin
            sweep($sformatf("rand%0d", i), 8'($urandom), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sop_sweep_checker.md
# sop_sweep_checker

Parametrised, clocked, self-checking exhaustive sweeper for N-input combinational logic blocks, such as the team's sum-of-products examples. It drives every input combination 0 to 2^N_IN-1 in order and holds each vector for a programmable number of cycles. At the end of each hold window it compares the device-under-test output against a truth-table parameter. It reports pass/fail, mismatch count and the first failing vector, so the check runs in hardware or simulation without hand-written waveform stimulus.

## Interface
Parameters:
- N_IN, default 3: number of DUT inputs; legal range 1–8.
- HOLD, default 10: cycles each vector is held; must be ≥1.
- EXPECT, default 8'b1110_1000: expected truth table, width 2^N_IN; bit v is the expected y for input vector v. The default is 3-input majority.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sweep. Sampled in IDLE and DONE only.
- dut_y, input, 1: DUT output under test.
- dut_in, output, N_IN: vector driven to the DUT.
- busy, output, 1: high while a sweep runs.
- done, output, 1: high (level) once a sweep completes, until the next start or reset.
- pass, output, 1: valid when done; 1 when err_count==0.
- err_count, output, N_IN+1: number of mismatching vectors. This width cannot overflow.
- first_err_valid, output, 1: at least one mismatch recorded.
- first_err_vec, output, N_IN: lowest-index failing vector; 0 when no error has been recorded.

## Operation
- States:
  - IDLE → RUN on start.
  - RUN → DONE after the last vector is sampled.
  - DONE → RUN on start.
  - No other transitions.
- Entering RUN:
  - dut_in=0, hold counter=0.
  - err_count, first_err_valid and first_err_vec cleared.
  - done=0, busy=1.
- In RUN, the hold counter counts 0..HOLD-1.
- When the counter equals HOLD-1, on that edge:
  - dut_y is compared with EXPECT[dut_in].
  - On mismatch, err_count increments. If first_err_valid=0, first_err_vec is set to dut_in and first_err_valid is set to 1.
  - If dut_in == 2^N_IN-1 → DONE. Otherwise dut_in increments and the counter returns to 0.
- In DONE:
  - busy=0, done=1, pass = (err_count==0).
  - dut_in holds its last value.
- start while busy is ignored; it is neither queued nor restarts the sweep.
- Reset, asynchronous, at any time including mid-sweep:
  - state=IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, hold counter=0.
- Arithmetic:
  - dut_in and the hold counter are unsigned and never wrap; the sweep terminates first.
  - The hold counter width is clog2(HOLD) with a minimum of 1 bit.

## Timing
- start high at rising edge E0 (in IDLE or DONE): from E0, busy=1 and dut_in=0.
- Vector v is driven between edges E0+v·HOLD and E0+(v+1)·HOLD.
- dut_y is sampled at edge E0+(v+1)·HOLD. The DUT therefore has HOLD cycles, minus clock-to-out, to settle.
- At edge E0+2^N_IN·HOLD: busy falls, done rises, and pass/err_count are final.
- Total sweep latency is exactly 2^N_IN·HOLD cycles.
- Outputs are registered, with no combinational path from dut_y or start.
- HOLD=1: the vector advances and is sampled every cycle; the DUT must be combinational within one cycle.

## Configuration
- SOP_SWEEP_STOP_ON_ERR_EN
  - Defined: the first mismatch sends RUN → DONE on the sampling edge. err_count=1, first_err_vec=failing vector, pass=0, and dut_in stays at the failing vector.
  - Undefined (default): the sweep always completes all 2^N_IN vectors and counts every mismatch.

## Test plan
All scenarios use N_IN=3, HOLD=10, EXPECT=8'b1110_1000, with a combinational model driving dut_y. The first four run with the macro undefined.
- Correct majority model; start pulsed once at edge E0:
  - busy high for 80 cycles.
  - dut_in steps 0..7 every 10 cycles.
  - At E0+80: done=1, pass=1, err_count=0, first_err_valid=0.
- Model with dut_y stuck at 0:
  - done at E0+80, pass=0, err_count=4, first_err_vec=3, first_err_valid=1.
- Model correct except vector 5 inverted:
  - err_count=1, first_err_vec=5.
  - Repeat with HOLD=1: done at E0+8 with the same result.
- rst_n pulsed low at E0+35 (mid vector 3):
  - All outputs 0 immediately, before the next clock edge.
  - Fresh start after release: a full, correct 80-cycle sweep, pass=1.
- start held high for 20 cycles from E0:
  - Sweep is not restarted; done still at E0+80.
  - start pulsed again in DONE clears done/err_count and begins a new sweep at dut_in=0.
- With SOP_SWEEP_STOP_ON_ERR_EN defined, dut_y stuck at 0:
  - done=1 at E0+40, busy=0, err_count=1, first_err_vec=3, dut_in=3, pass=0.
